enemy_wave: RTL

Parametrised successor to the fixed three-enemy chain. It renders one formation of ENEMY_COUNT enemies that move as a block: sideways, bouncing off the screen edges, and dropping one row at each bounce. It detects missile hits per enemy, counts kills, and respawns the wave after it is cleared. It sits in the VGA pipeline between the background/player stage and the output stage, and passes timing signals through with fixed latency.

---
 rtl/enemy_wave.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/enemy_wave.sv
// Formation of ENEMY_COUNT enemies moving as one block, with missile hits, kill counting,
// wave respawn and a 2-cycle render pipeline inserted in the VGA timing path.
`timescale 1ns/1ps
module enemy_wave #(
  parameter int          ENEMY_COUNT    = 6,
  parameter int          EN_W           = 32,
  parameter int          EN_H           = 24,
  parameter int          SPACING        = 96,
  parameter int          X_START        = 64,
  parameter int          Y_TOP          = 48,
  parameter int          X_MIN          = 16,
  parameter int          X_MAX          = 784,
  parameter int          DROP           = 16,
  parameter int          Y_LIMIT        = 480,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [11:0] ENEMY_RGB      = 12'hF00
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [4:0]  level,
  input  logic [10:0] xpos_missile,
  input  logic [10:0] ypos_missile,
  input  logic        on_missle,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic        hit,
  output logic        wave_cleared,
  output logic        breach,
  output logic [7:0]  kills
);

  typedef enum logic [1:0] {RUN, CLEAR_WAIT, RESPAWN} state_t;

  localparam logic [11:0]            SPAN = 12'((ENEMY_COUNT-1)*SPACING + EN_W);
  localparam logic [11:0]            W_M1 = 12'(EN_W-1);
  localparam logic [11:0]            H_M1 = 12'(EN_H-1);
  localparam logic [ENEMY_COUNT-1:0] ALL  = '1;

  state_t                 state;
  logic [ENEMY_COUNT-1:0] alive, box_pix, box_mis, cand, kill_oh, survivors;
  logic [11:0]            form_x, form_y, dx;
  logic                   dir;  // 1 = moving right
  logic [15:0]            frames;
  logic                   vblnk_prev, tick, bounce, too_deep, kill_any, in_enemy;

  // stage-1 registers of the render pipeline
  logic [10:0] vc1, hc1;
  logic        vs1, vb1, hs1, hb1, in1;
  logic [11:0] rgb1;

  function automatic logic in_box(input logic [11:0] px, py, bx, by);
    return (px >= bx) && (px <= bx + W_M1) && (py >= by) && (py <= by + H_M1);
  endfunction

  generate
    for (genvar i = 0; i < ENEMY_COUNT; i++) begin : g_enemy
      localparam logic [11:0] OFF = 12'(i*SPACING);
      logic [11:0] bx;
      assign bx         = form_x + OFF;
      assign box_pix[i] = alive[i] && in_box({1'b0, hcount_in}, {1'b0, vcount_in}, bx, form_y);
      assign box_mis[i] = alive[i] && in_box({1'b0, xpos_missile}, {1'b0, ypos_missile}, bx, form_y);
    end
  endgenerate

  assign tick      = vblnk_in & ~vblnk_prev;
  assign dx        = (level <= 5'd3) ? 12'(level) + 12'd1 : 12'd4;
  assign bounce    = dir ? (form_x + dx + SPAN > 12'(X_MAX)) : (form_x < 12'(X_MIN) + dx);
  assign too_deep  = form_y + 12'(DROP + EN_H) > 12'(Y_LIMIT);
  // lowest-index candidate wins: isolate the least significant set bit
  assign cand      = (state == RUN && on_missle) ? box_mis : '0;
  assign kill_oh   = cand & (~cand + ENEMY_COUNT'(1));
  assign kill_any  = |cand;
  assign survivors = alive & ~kill_oh;
  assign in_enemy  = (state == RUN) && (|box_pix);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= RUN;
      alive        <= ALL;
      form_x       <= 12'(X_START);
      form_y       <= 12'(Y_TOP);
      dir          <= 1'b1;
      frames       <= '0;
      vblnk_prev   <= 1'b0;
      hit          <= 1'b0;
      wave_cleared <= 1'b0;
      breach       <= 1'b0;
      kills        <= '0;
    end else begin
      vblnk_prev   <= vblnk_in;
      hit          <= kill_any;
      wave_cleared <= 1'b0;
      breach       <= 1'b0;
      case (state)
        RUN: begin
          if (kill_any) begin
            alive <= survivors;
            if (kills != 8'hFF) kills <= kills + 8'd1;
            if (survivors == '0) begin
              wave_cleared <= 1'b1;
              state        <= CLEAR_WAIT;
            end
          end
          if (tick) begin
            if (bounce) begin
              // a bounce past the bottom restarts at the top without flipping direction
              if (too_deep) begin
                breach <= 1'b1;
                form_y <= 12'(Y_TOP);
              end else begin
                form_y <= form_y + 12'(DROP);
                dir    <= ~dir;
              end
            end else begin
              form_x <= dir ? form_x + dx : form_x - dx;
            end
          end
        end
        CLEAR_WAIT: begin
          if (tick) begin
            if (frames == 16'(RESPAWN_FRAMES-1)) begin
              frames <= '0;
              state  <= RESPAWN;
            end else begin
              frames <= frames + 16'd1;
            end
          end
        end
        default: begin
          alive  <= ALL;
          form_x <= 12'(X_START);
          form_y <= 12'(Y_TOP);
          dir    <= 1'b1;
          state  <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vc1 <= '0; hc1 <= '0; vs1 <= 1'b0; vb1 <= 1'b0; hs1 <= 1'b0; hb1 <= 1'b0;
      rgb1 <= '0; in1 <= 1'b0;
      vcount_out <= '0; hcount_out <= '0; vsync_out <= 1'b0; vblnk_out <= 1'b0;
      hsync_out <= 1'b0; hblnk_out <= 1'b0; rgb_out <= '0;
    end else begin
      vc1  <= vcount_in;  hc1 <= hcount_in;
      vs1  <= vsync_in;   vb1 <= vblnk_in;
      hs1  <= hsync_in;   hb1 <= hblnk_in;
      rgb1 <= rgb_in;     in1 <= in_enemy;
      vcount_out <= vc1;  hcount_out <= hc1;
      vsync_out  <= vs1;  vblnk_out  <= vb1;
      hsync_out  <= hs1;  hblnk_out  <= hb1;
      rgb_out    <= (in1 && !vb1 && !hb1) ? ENEMY_RGB : rgb1;
    end
  end

endmodule
